// File: rtl/fetch_pkg.sv
// Shared types and default constants for the instruction-fetch stage.
//   fetch_state_t   : BOOT (memory settle cycle after reset), RUN (sequential
//                     fetch), HALTED (halt word seen, waiting for a redirect)
//   DEF_ADDR_W      : default PC / instruction-memory byte-address width
//   DEF_NOP_WORD    : default word placed in IF/ID on flush or bubble
//   DEF_HALT_WORD   : default fetched word that stops sequential fetch
package fetch_pkg;

  localparam int          DEF_ADDR_W    = 9;
  localparam logic [31:0] DEF_NOP_WORD  = 32'h0000_0000;
  localparam logic [31:0] DEF_HALT_WORD = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_ifid_reg.sv
// IF/ID pipeline register.
// Ports:
//   clk, reset        : rising-edge clock, synchronous active-high reset
//   load              : capture d_instr/d_pc/d_pc4 and mark the entry valid
//   flush             : replace the instruction with NOP_WORD and mark invalid;
//                       the PC fields hold (they are meaningless while invalid)
//   d_instr/d_pc/d_pc4: incoming instruction word, its PC and PC+4
//   instr/pc/pc4/valid: registered IF/ID contents
// Priority: reset > flush > load > hold.
module ifid_reg
  import fetch_pkg::*;
#(
  parameter int          ADDR_W   = DEF_ADDR_W,
  parameter logic [31:0] NOP_WORD = DEF_NOP_WORD
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              flush,
  input  logic [31:0]       d_instr,
  input  logic [ADDR_W-1:0] d_pc,
  input  logic [ADDR_W-1:0] d_pc4,
  output logic [31:0]       instr,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc4,
  output logic              valid
);

  always_ff @(posedge clk) begin
    if (reset) begin
      instr <= NOP_WORD;
      pc    <= '0;
      pc4   <= '0;
      valid <= 1'b0;
    end else if (flush) begin
      instr <= NOP_WORD;
      valid <= 1'b0;
    end else if (load) begin
      instr <= d_instr;
      pc    <= d_pc;
      pc4   <= d_pc4;
      valid <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage. Owns the PC, presents it to a combinational-read,
// big-endian instruction memory, and captures the returned word into IF/ID.
// Ports:
//   clk, reset   : rising-edge clock, synchronous active-high reset
//   stall        : hazard hold; PC and IF/ID freeze
//   redirect     : taken branch/jump; wins over stall
//   redirect_pc  : branch/jump target (low two bits dropped, misalign flagged)
//   imem_addr    : byte address to memory, always the PC register
//   imem_data    : word read from memory at imem_addr
//   ifid_instr/ifid_pc/ifid_pc4/ifid_valid : IF/ID register contents
//   halted       : high while in HALTED
//   misalign     : one-cycle pulse after a redirect to a non word-aligned target
//   dbg_state    : current FSM state, for observation only
// Edge priority: reset > redirect > stall > state action.
// There is no valid/ready handshake here: the stage produces one IF/ID entry
// per unstalled RUN cycle and ifid_valid marks real instructions vs bubbles.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                ADDR_W    = DEF_ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter logic [31:0]       NOP_WORD  = DEF_NOP_WORD,
  parameter logic [31:0]       HALT_WORD = DEF_HALT_WORD
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_data,
  output logic [31:0]       ifid_instr,
  output logic [ADDR_W-1:0] ifid_pc,
  output logic [ADDR_W-1:0] ifid_pc4,
  output logic              ifid_valid,
  output logic              halted,
  output logic              misalign,
  output fetch_state_t      dbg_state
);

  fetch_state_t      state, state_nxt;
  logic [ADDR_W-1:0] pc, pc_nxt, pc_plus4;
  logic              ifid_load, ifid_flush;

  // Natural width truncation gives the mod 2^ADDR_W wrap.
  assign pc_plus4  = pc + ADDR_W'(4);
  assign imem_addr = pc;
  assign halted    = (state == HALTED);
  assign dbg_state = state;

  always_comb begin
    state_nxt  = state;
    pc_nxt     = pc;
    ifid_load  = 1'b0;
    ifid_flush = 1'b0;
    if (redirect) begin
      // The word at the old PC is wrong-path: drop it and restart at the target.
      pc_nxt     = {redirect_pc[ADDR_W-1:2], 2'b00};
      ifid_flush = 1'b1;
      state_nxt  = RUN;
    end else if (!stall) begin
      case (state)
        BOOT: state_nxt = RUN;
        RUN: begin
          ifid_load = 1'b1;
          // The halt word goes to decode as a real instruction, but fetch
          // parks on it instead of advancing.
          if (imem_data == HALT_WORD) begin
            state_nxt = HALTED;
          end else begin
            pc_nxt = pc_plus4;
          end
        end
        HALTED:  ifid_flush = 1'b1;
        default: state_nxt = BOOT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= BOOT;
      pc       <= RESET_PC;
      misalign <= 1'b0;
    end else begin
      state    <= state_nxt;
      pc       <= pc_nxt;
      misalign <= redirect & (|redirect_pc[1:0]);
    end
  end

  ifid_reg #(
    .ADDR_W  (ADDR_W),
    .NOP_WORD(NOP_WORD)
  ) u_ifid (
    .clk    (clk),
    .reset  (reset),
    .load   (ifid_load),
    .flush  (ifid_flush),
    .d_instr(imem_data),
    .d_pc   (pc),
    .d_pc4  (pc_plus4),
    .instr  (ifid_instr),
    .pc     (ifid_pc),
    .pc4    (ifid_pc4),
    .valid  (ifid_valid)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed sequence then randomized traffic. A driver
// applies inputs on the falling edge and pushes the reference model's view of
// the outputs after the next rising edge; a monitor pops and compares field by
// field 1 time unit after each rising edge.
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam int          W    = 64;
  localparam logic [31:0] NOP  = 32'h0000_0000;
  localparam logic [31:0] HALT = 32'hFFFF_FFFF;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset = 1'b1;
  logic         stall = 1'b0;
  logic         redirect = 1'b0;
  logic [8:0]   redirect_pc = '0;
  logic [8:0]   imem_addr;
  logic [31:0]  imem_data;
  logic [31:0]  ifid_instr;
  logic [8:0]   ifid_pc;
  logic [8:0]   ifid_pc4;
  logic         ifid_valid;
  logic         halted;
  logic         misalign;
  fetch_state_t dbg_state;

  // Word-organised view of the 512-byte memory; addresses are always aligned.
  logic [31:0] mem_w [128];
  assign imem_data = mem_w[imem_addr[8:2]];

  fetch_unit dut (
    .clk        (clk),
    .reset      (reset),
    .stall      (stall),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .imem_addr  (imem_addr),
    .imem_data  (imem_data),
    .ifid_instr (ifid_instr),
    .ifid_pc    (ifid_pc),
    .ifid_pc4   (ifid_pc4),
    .ifid_valid (ifid_valid),
    .halted     (halted),
    .misalign   (misalign),
    .dbg_state  (dbg_state)
  );

  // scoreboard
  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: spec-level fetch behaviour
  int           m_pc = 0;
  fetch_state_t m_st = BOOT;
  logic [31:0]  m_instr = NOP;
  int           m_ipc = 0;
  int           m_ipc4 = 0;
  logic         m_valid = 1'b0;
  logic         m_mis = 1'b0;

  task automatic model_edge(input logic r, input logic s, input logic rd, input logic [8:0] rpc);
    logic [31:0] word;
    if (r) begin
      m_pc = 0; m_st = BOOT; m_instr = NOP; m_ipc = 0; m_ipc4 = 0;
      m_valid = 1'b0; m_mis = 1'b0;
    end else if (rd) begin
      m_pc    = (int'(rpc) / 4) * 4;
      m_instr = NOP;
      m_valid = 1'b0;
      m_st    = RUN;
      m_mis   = (int'(rpc) % 4) != 0;
    end else begin
      m_mis = 1'b0;
      if (!s) begin
        if (m_st == BOOT) begin
          m_st = RUN;
        end else if (m_st == RUN) begin
          word    = mem_w[m_pc / 4];
          m_instr = word;
          m_ipc   = m_pc;
          m_ipc4  = (m_pc + 4) % 512;
          m_valid = 1'b1;
          if (word == HALT) m_st = HALTED;
          else m_pc = (m_pc + 4) % 512;
        end else begin
          m_instr = NOP;
          m_valid = 1'b0;
        end
      end
    end
  endtask

  // driver: apply one cycle of inputs and record the expected result
  task automatic step(input logic r, input logic s, input logic rd, input logic [8:0] rpc);
    @(negedge clk);
    reset = r; stall = s; redirect = rd; redirect_pc = rpc;
    model_edge(r, s, rd, rpc);
    exp_q.push_back({m_instr, 9'(m_ipc), 9'(m_ipc4), m_valid,
                     logic'(m_st == HALTED), m_mis, 9'(m_pc), 2'(m_st)});
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 9'h000);
  endtask

  // monitor
  initial begin
    logic [W-1:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("ifid_instr", ifid_instr,          e[63:32]);
        chk("ifid_pc",    32'(ifid_pc),        32'(e[31:23]));
        chk("ifid_pc4",   32'(ifid_pc4),       32'(e[22:14]));
        chk("ifid_valid", 32'(ifid_valid),     32'(e[13]));
        chk("halted",     32'(halted),         32'(e[12]));
        chk("misalign",   32'(misalign),       32'(e[11]));
        chk("imem_addr",  32'(imem_addr),      32'(e[10:2]));
        chk("state",      32'(dbg_state),      32'(e[1:0]));
      end
    end
  end

  // stimulus
  initial begin
    for (int i = 0; i < 128; i++) mem_w[i] = 32'h1000_0000 + i;
    mem_w[0]   = 32'hAAAA_0001;
    mem_w[1]   = 32'hBBBB_0002;
    mem_w[2]   = 32'hCCCC_0003;
    mem_w[3]   = 32'hDDDD_0004;
    mem_w[4]   = HALT;
    mem_w[16]  = 32'h4040_4040;
    mem_w[17]  = 32'h4444_4444;
    mem_w[127] = 32'h1FC0_1FC0;

    step(1'b1, 1'b0, 1'b0, 9'h000);
    step(1'b1, 1'b0, 1'b0, 9'h000);
    run(3);                                   // BOOT, A@0, B@4
    step(1'b0, 1'b1, 1'b0, 9'h000);           // stall at pc=0x008
    step(1'b0, 1'b1, 1'b0, 9'h000);
    run(3);                                   // C, D, HALT@0x010
    run(3);                                   // bubbles while halted
    step(1'b0, 1'b0, 1'b1, 9'h000);           // leave HALTED
    run(2);
    step(1'b0, 1'b1, 1'b1, 9'h040);           // redirect beats stall
    run(2);
    step(1'b0, 1'b0, 1'b1, 9'h043);           // misaligned target
    run(2);
    step(1'b0, 1'b0, 1'b1, 9'h1FC);           // wrap case
    run(3);
    step(1'b0, 1'b0, 1'b1, 9'h010);           // halt again
    run(2);
    step(1'b1, 1'b0, 1'b0, 9'h000);           // reset mid-HALTED
    run(3);
    step(1'b1, 1'b1, 1'b1, 9'h044);           // reset beats redirect and stall

    for (int i = 0; i < 128; i++)
      mem_w[i] = ($urandom_range(0, 11) == 0) ? HALT : $urandom();
    for (int i = 0; i < 400; i++) begin
      step(logic'($urandom_range(0, 63) == 0),
           logic'($urandom_range(0, 3) == 0),
           logic'($urandom_range(0, 7) == 0),
           9'($urandom_range(0, 511)));
    end
    step(1'b0, 1'b0, 1'b0, 9'h000);

    repeat (3) @(negedge clk);
    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
